// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: default widths, bit ordering
// and the slave-port state encoding.
package bus_pkg;

  localparam int BUS_ADDR_W = 12;
  localparam int BUS_DATA_W = 8;

  // Serial streams carry the most significant bit first; master_port relies on this too.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    SP_IDLE    = 3'd0,
    SP_RX_ADDR = 3'd1,
    SP_RX_DATA = 3'd2,
    SP_MEM_REQ = 3'd3,
    SP_RD_WAIT = 3'd4,
    SP_TX_DATA = 3'd5
  } sp_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_reg_sipo_piso.sv
// Shift register with serial input, parallel load and serial output, ordered
// according to the bus bit-ordering constant.
module shift_reg_sipo_piso
  import bus_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_en,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         serial_in,
  output logic [W-1:0] q,
  output logic         serial_out
);

  logic [W-1:0] q_r;

  // Storage: parallel load takes priority over a shift in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_r <= '0;
    end else if (load_en) begin
      q_r <= load_data;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        q_r <= {q_r[W-2:0], serial_in};
      end else begin
        q_r <= {serial_in, q_r[W-1:1]};
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q          = q_r;
  assign serial_out = MSB_FIRST ? q_r[W-1] : q_r[0];

endmodule

// File: rtl/slave_port.sv
// Serial-bus slave port: collects address/write data bits into a parallel slave
// request and streams read data back to the master one bit per beat.
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sp_addr,
  input  logic              sp_wr_data,
  input  logic              sp_wr_en,
  input  logic              sp_master_valid,
  input  logic              sp_master_ready,
  output logic              sp_rd_data,
  output logic              sp_slave_ready,
  output logic              sp_slave_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wr_data,
  output logic              s_wr_en,
  output logic              s_valid,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rd_data,
  input  logic              s_rd_valid
);

  localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W));

  sp_state_e         state_r, state_s;
  logic [CNT_W-1:0]  count_r, count_s;
  logic              wr_en_r, wr_en_s;
  logic              addr_shift_s;
  logic              data_shift_s;
  logic              data_load_s;
  logic              data_serial_s;
  logic [ADDR_W-1:0] addr_q_s;
  logic [DATA_W-1:0] data_q_s;
  logic              data_msb_s;
  logic              addr_msb_unused_s;

  // Address shifter only ever shifts in; its serial output has no consumer.
  shift_reg_sipo_piso #(.W(ADDR_W)) u_addr_sr (
    .clk        (clk),
    .rstn       (rstn),
    .load_en    (1'b0),
    .load_data  ({ADDR_W{1'b0}}),
    .shift_en   (addr_shift_s),
    .serial_in  (sp_addr),
    .q          (addr_q_s),
    .serial_out (addr_msb_unused_s)
  );

  // Data shifter is shared: write data shifts in, read data loads then shifts out.
  shift_reg_sipo_piso #(.W(DATA_W)) u_data_sr (
    .clk        (clk),
    .rstn       (rstn),
    .load_en    (data_load_s),
    .load_data  (s_rd_data),
    .shift_en   (data_shift_s),
    .serial_in  (data_serial_s),
    .q          (data_q_s),
    .serial_out (data_msb_s)
  );

  // State, bit counter and transfer direction registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= SP_IDLE;
      count_r <= '0;
      wr_en_r <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      wr_en_r <= wr_en_s;
    end
  end

  // Next-state, counter and shifter control; beats only occur in states that handshake.
  always_comb begin
    state_s       = state_r;
    count_s       = count_r;
    wr_en_s       = wr_en_r;
    addr_shift_s  = 1'b0;
    data_shift_s  = 1'b0;
    data_load_s   = 1'b0;
    data_serial_s = 1'b0;
    case (state_r)
      SP_IDLE: begin
        if (sp_master_valid) begin
          addr_shift_s = 1'b1;
          wr_en_s      = sp_wr_en;
          count_s      = CNT_W'(1);
          state_s      = SP_RX_ADDR;
        end else begin
          state_s = SP_IDLE;
        end
      end
      SP_RX_ADDR: begin
        if (sp_master_valid) begin
          addr_shift_s = 1'b1;
          if (count_r == CNT_W'(ADDR_W - 1)) begin
            count_s = '0;
            state_s = wr_en_r ? SP_RX_DATA : SP_MEM_REQ;
          end else begin
            count_s = count_r + CNT_W'(1);
          end
        end else begin
          state_s = SP_RX_ADDR;
        end
      end
      SP_RX_DATA: begin
        data_serial_s = sp_wr_data;
        if (sp_master_valid) begin
          data_shift_s = 1'b1;
          if (count_r == CNT_W'(DATA_W - 1)) begin
            count_s = '0;
            state_s = SP_MEM_REQ;
          end else begin
            count_s = count_r + CNT_W'(1);
          end
        end else begin
          state_s = SP_RX_DATA;
        end
      end
      SP_MEM_REQ: begin
        if (s_ready) begin
          state_s = wr_en_r ? SP_IDLE : SP_RD_WAIT;
        end else begin
          state_s = SP_MEM_REQ;
        end
      end
      SP_RD_WAIT: begin
        if (s_rd_valid) begin
          data_load_s = 1'b1;
          count_s     = '0;
          state_s     = SP_TX_DATA;
        end else begin
          state_s = SP_RD_WAIT;
        end
      end
      SP_TX_DATA: begin
        if (sp_master_ready) begin
          data_shift_s = 1'b1;
          if (count_r == CNT_W'(DATA_W - 1)) begin
            count_s = '0;
            state_s = SP_IDLE;
          end else begin
            count_s = count_r + CNT_W'(1);
          end
        end else begin
          state_s = SP_TX_DATA;
        end
      end
      default: begin
        count_s = '0;
        state_s = SP_IDLE;
      end
    endcase
  end

  // Bus and slave handshake outputs decoded from the current state.
  always_comb begin
    sp_slave_ready = 1'b0;
    sp_slave_valid = 1'b0;
    sp_rd_data     = 1'b0;
    s_valid        = 1'b0;
    case (state_r)
      SP_IDLE, SP_RX_ADDR, SP_RX_DATA: sp_slave_ready = 1'b1;
      SP_MEM_REQ:                      s_valid        = 1'b1;
      SP_TX_DATA: begin
        sp_slave_valid = 1'b1;
        sp_rd_data     = data_msb_s;
      end
      SP_RD_WAIT:                      s_valid        = 1'b0;
      default:                         sp_slave_ready = 1'b0;
    endcase
  end

  assign s_addr    = addr_q_s;
  assign s_wr_data = data_q_s;
  assign s_wr_en   = wr_en_r;

endmodule

// File: doc/slave_port.md
# slave_port

Bus-side slave port for the serial system bus. It deserialises the MSB-first address and write-data bit streams driven by a granted master port and presents complete parallel transactions to a local slave (memory or peripheral). For reads, it fetches the data word from the slave and serialises it back onto the bus. It sits between the bus interconnect (address decode/mux) and one slave device.

## Interface
- ADDR_W, 12: local slave address width in bits; device-select bits are stripped by the interconnect.
- DATA_W, 8: data word width in bits.

- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- sp_addr  in  1  serial address bit, MSB first.
- sp_wr_data  in  1  serial write-data bit, MSB first.
- sp_wr_en  in  1  1 = write, 0 = read; stable for the whole transaction.
- sp_master_valid  in  1  master drives a valid address/data bit this cycle.
- sp_master_ready  in  1  master accepts a read-data bit this cycle.
- sp_rd_data  out  1  serial read-data bit, MSB first.
- sp_slave_ready  out  1  port accepts an address/data bit this cycle.
- sp_slave_valid  out  1  sp_rd_data is valid.
- s_addr  out  ADDR_W  parallel address to slave.
- s_wr_data  out  DATA_W  parallel write data to slave.
- s_wr_en  out  1  request is a write.
- s_valid  out  1  request valid toward slave.
- s_ready  in  1  slave accepts request.
- s_rd_data  in  DATA_W  slave read data.
- s_rd_valid  in  1  s_rd_data valid (single-cycle pulse).

## Operation
- Bus beat (inbound): a cycle with sp_master_valid && sp_slave_ready. Bus beat (outbound): a cycle with sp_slave_valid && sp_master_ready. Cycles without a beat hold all state; there is no timeout.
- States: IDLE, RX_ADDR, RX_DATA, MEM_REQ, RD_WAIT, TX_DATA.
- IDLE: sp_slave_ready=1. The first inbound beat shifts the bit into the address register, latches sp_wr_en, sets count=1, and moves to RX_ADDR.
- RX_ADDR: sp_slave_ready=1. Each beat shifts left and inserts sp_addr at the LSB, then increments count. On the beat where count==ADDR_W-1: clear count, then go to RX_DATA if writing, or MEM_REQ if reading.
- RX_DATA: sp_slave_ready=1. Shift in sp_wr_data. On the beat where count==DATA_W-1, go to MEM_REQ.
- MEM_REQ: s_valid=1, with s_addr, s_wr_data and s_wr_en held from the registers. On s_ready: a write goes to IDLE; a read goes to RD_WAIT.
- RD_WAIT: on s_rd_valid, load s_rd_data into the shift register, clear count, and go to TX_DATA. An s_rd_valid pulse outside RD_WAIT is ignored.
- TX_DATA: sp_slave_valid=1 and sp_rd_data=shreg[DATA_W-1]. Each outbound beat shifts left and increments count. After the beat where count==DATA_W-1, go to IDLE.
- sp_slave_ready=0 in MEM_REQ, RD_WAIT and TX_DATA. sp_slave_valid=0 outside TX_DATA.
- Count width: $clog2(max(ADDR_W,DATA_W)). No wrap occurs in legal operation.
- Illegal state encoding: next state is IDLE.

## Timing
- Reset values: state=IDLE, count=0, all shift registers 0. Outputs: sp_slave_ready=1; sp_slave_valid, sp_rd_data, s_valid and s_wr_en are 0; s_addr and s_wr_data are 0.
- Reset mid-transaction returns the port to IDLE immediately. It does not complete the slave request.
- All bus and slave outputs are decoded combinationally from state and registers. Registers only update on posedge clk.
- Write latency: ADDR_W+DATA_W inbound beats, then s_valid rises in the next cycle.
- Read latency: s_valid rises one cycle after the last address beat. sp_slave_valid rises one cycle after s_rd_valid.
- Zero-wait case: s_ready asserted in the first cycle of MEM_REQ means the request is held for exactly 1 cycle.
- Back-to-back: after a write handshake, IDLE is entered on the next edge, and the following first beat can be accepted in that same IDLE cycle.

## Structure
- Shared package bus_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the slave_port state enum;
  - bit-ordering constant MSB_FIRST, also used by master_port.
- One sub-module, shift_reg_sipo_piso: width parameter, serial-in/parallel-load, shift-enable, MSB serial-out.
  - Instantiated twice: once for the address, once for data (shared between write-in and read-out).

## Test plan
- Write 0xA5 to address 0x3C7 with sp_master_valid held high → after 20 beats, s_valid=1, s_addr=0x3C7, s_wr_data=0xA5, s_wr_en=1. IDLE is reached one cycle after s_ready.
- Read address 0x0F0; slave returns 0x5A three cycles after s_ready → sp_rd_data sequence 0,1,0,1,1,0,1,0 with sp_slave_valid=1 over 8 cycles, then IDLE.
- Write with sp_master_valid dropped for 4 cycles after address bit 5 → counter and shift registers are frozen, and the final s_addr/s_wr_data are still correct.
- Read with sp_master_ready low on alternate cycles → each bit is held until accepted, and 8 bits are delivered in 16 cycles.
- s_ready held low for 5 cycles in MEM_REQ → s_valid and s_addr stay stable for all 6 cycles, and sp_slave_ready=0 throughout.
- rstn asserted during RX_DATA bit 3, then released → all outputs are at reset values, and a fresh write of 0x11 to 0x001 completes correctly.
